mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle main control FSM for the MIPS core. Sequences one instruction through fetch, decode, execute, memory and writeback states, and drives the write enables and mux selects for the IFU, register file, ALU and data memory. It is the only source of `pc_we`/`npc_sel`, so the PC advances exactly once per instruction, in that instruction's final state.

## Interface
Parameters: none (encodings come from `defines.v`).

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- op  in  6  instr[31:26] of the latched IR
- funct  in  6  instr[5:0] of the latched IR
- zero  in  1  ALU zero flag, valid in BRANCH
- im_rdy  in  1  instruction memory ready (only with MC_CTRL_WAIT_EN)
- dm_rdy  in  1  data memory ready (only with MC_CTRL_WAIT_EN)
- ir_we  out  1  latch instruction register
- pc_we  out  1  IFU PC update enable
- npc_sel  out  2  IFU next-PC select, `IFU_SEL_*` encodings
- rf_we  out  1  register file write enable
- rf_wsel  out  2  dest: 0=rt, 1=rd, 2=$31
- rf_dsel  out  2  write data: 0=ALU, 1=DM, 2=PC+4
- alu_op  out  3  0=ADD, 1=SUB, 2=OR, 3=LUI
- alu_bsel  out  1  0=rt, 1=extended immediate
- ext_op  out  1  0=zero-extend, 1=sign-extend
- dm_re / dm_we  out  1 / 1  data memory read/write strobes
- illegal  out  1  one-cycle pulse on unsupported instruction
- state  out  4  current state, for debug

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP.
- All outputs are Moore, decoded from state plus latched op/funct. Every output not listed for a state is 0. Reset forces state=FETCH, and all outputs are 0 during reset.
- FETCH: ir_we=1. Next state is DECODE.
- DECODE dispatch:
  - R-type (op=0) with funct addu 0x21 / subu 0x23 → EXEC_R.
  - ori 0x0D, lui 0x0F → EXEC_I.
  - lw 0x23, sw 0x2B → MEM_ADDR.
  - beq 0x04 → BRANCH.
  - j 0x02, jal 0x03, jr (op 0, funct 0x08) → JUMP.
  - Anything else: illegal=1, pc_we=1, npc_sel=NORM, next FETCH.
- EXEC_R: alu_bsel=0; alu_op=ADD for addu, SUB for subu. Next WB_ALU.
- EXEC_I: alu_bsel=1, ext_op=0; alu_op=OR for ori, LUI for lui. Next WB_ALU.
- WB_ALU: rf_we=1, rf_dsel=0; rf_wsel=1 for R-type, 0 for I-type; pc_we=1, npc_sel=NORM. Next FETCH.
- MEM_ADDR: alu_op=ADD, alu_bsel=1, ext_op=1. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: dm_re=1, ALU controls held from MEM_ADDR. Next WB_MEM.
- WB_MEM: rf_we=1, rf_wsel=0, rf_dsel=1, pc_we=1, npc_sel=NORM. Next FETCH.
- MEM_WR: dm_we=1, ALU controls held, pc_we=1, npc_sel=NORM. Next FETCH.
- BRANCH: alu_op=SUB, alu_bsel=0, pc_we=1. npc_sel=RELATIVE if zero, else NORM. Next FETCH.
- JUMP: pc_we=1.
  - j/jal: npc_sel=IRRELATIVE. jal also asserts rf_we=1, rf_wsel=2, rf_dsel=2.
  - jr: npc_sel=REGISTER.
  - Next FETCH.
- The PC is not modified before the final state, so RELATIVE and PC+4 are computed from the current instruction's address.

## Timing
- Cycles per instruction:
  - beq, j, jal, jr: 3.
  - addu, subu, ori, lui, sw: 4.
  - lw: 5.
  - Illegal: 2.
- pc_we is high for exactly one cycle per instruction.
- rf_we and pc_we coincide in the final state. The register write and the PC update commit on the same edge.
- ir_we is high only in FETCH. op/funct must be stable from DECODE to the end of the instruction.
- Reset asserted mid-instruction aborts it immediately: no pc_we or rf_we is issued, and execution resumes in FETCH after release.

## Configuration
- `MC_CTRL_WAIT_EN` defined:
  - im_rdy and dm_rdy ports exist.
  - FETCH holds, with ir_we asserted, until im_rdy=1. The IR is latched and the FSM leaves on the edge where im_rdy=1.
  - MEM_RD holds with dm_re=1, and MEM_WR holds with dm_we=1, until dm_rdy=1.
  - pc_we in MEM_WR asserts only in the dm_rdy=1 cycle.
- Not defined: the ports are absent, every state lasts one cycle, and memories are single-cycle.

## Test plan
- Reset, then addu (op 0, funct 0x21): state sequence FETCH→DECODE→EXEC_R→WB_ALU, with rf_we=1, rf_wsel=1, pc_we=1, npc_sel=NORM in cycle 4.
- lw then sw back-to-back: lw asserts dm_re in cycle 4 and rf_dsel=1 in cycle 5; sw asserts dm_we with pc_we in cycle 4 of its instruction; 9 cycles total.
- beq with zero=1: npc_sel=RELATIVE, pc_we=1 in cycle 3. Repeat with zero=0: npc_sel=NORM.
- jal: cycle 3 has npc_sel=IRRELATIVE, rf_we=1, rf_wsel=2, rf_dsel=2. jr: npc_sel=REGISTER, rf_we=0.
- op=0x3F: illegal pulses one cycle in DECODE with pc_we=1, npc_sel=NORM, then FETCH. Reset asserted in MEM_RD: next cycle state=FETCH and all outputs 0.
- With MC_CTRL_WAIT_EN, im_rdy low for 3 cycles: FETCH held 4 cycles and DECODE follows. dm_rdy low for 2 cycles during sw: dm_we held 3 cycles and pc_we only in the last.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main control FSM for the MIPS core (fetch/decode/execute/memory/writeback).
// Define MC_CTRL_WAIT_EN to add the im_rdy/dm_rdy memory handshake ports and wait states.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
`ifdef MC_CTRL_WAIT_EN
    input  logic       im_rdy,
    input  logic       dm_rdy,
`endif
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] npc_sel,
    output logic       rf_we,
    output logic [1:0] rf_wsel,
    output logic [1:0] rf_dsel,
    output logic [2:0] alu_op,
    output logic       alu_bsel,
    output logic       ext_op,
    output logic       dm_re,
    output logic       dm_we,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [1:0] IFU_SEL_NORM       = 2'd0;
    localparam logic [1:0] IFU_SEL_RELATIVE   = 2'd1;
    localparam logic [1:0] IFU_SEL_IRRELATIVE = 2'd2;
    localparam logic [1:0] IFU_SEL_REGISTER   = 2'd3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        WB_MEM   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10
    } state_t;

    state_t state_q;
    logic   im_ok;
    logic   dm_ok;

`ifdef MC_CTRL_WAIT_EN
    assign im_ok = im_rdy;
    assign dm_ok = dm_rdy;
`else
    assign im_ok = 1'b1;
    assign dm_ok = 1'b1;
`endif

    logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal;

    always_comb begin
        is_rtype = (op == 6'h00);
        is_addu  = is_rtype && (funct == 6'h21);
        is_subu  = is_rtype && (funct == 6'h23);
        is_jr    = is_rtype && (funct == 6'h08);
        is_ori   = (op == 6'h0D);
        is_lui   = (op == 6'h0F);
        is_lw    = (op == 6'h23);
        is_sw    = (op == 6'h2B);
        is_beq   = (op == 6'h04);
        is_j     = (op == 6'h02);
        is_jal   = (op == 6'h03);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:    if (im_ok) state_q <= DECODE;
                DECODE: begin
                    if (is_addu || is_subu)          state_q <= EXEC_R;
                    else if (is_ori || is_lui)       state_q <= EXEC_I;
                    else if (is_lw || is_sw)         state_q <= MEM_ADDR;
                    else if (is_beq)                 state_q <= BRANCH;
                    else if (is_j || is_jal || is_jr) state_q <= JUMP;
                    else                             state_q <= FETCH;
                end
                EXEC_R:   state_q <= WB_ALU;
                EXEC_I:   state_q <= WB_ALU;
                MEM_ADDR: state_q <= is_lw ? MEM_RD : MEM_WR;
                MEM_RD:   if (dm_ok) state_q <= WB_MEM;
                MEM_WR:   if (dm_ok) state_q <= FETCH;
                default:  state_q <= FETCH;
            endcase
        end
    end

    assign state = state_q;

    // Outputs decode from the current state and the latched op/funct; reset silences them all.
    always_comb begin
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        npc_sel  = IFU_SEL_NORM;
        rf_we    = 1'b0;
        rf_wsel  = 2'd0;
        rf_dsel  = 2'd0;
        alu_op   = ALU_ADD;
        alu_bsel = 1'b0;
        ext_op   = 1'b0;
        dm_re    = 1'b0;
        dm_we    = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: ir_we = 1'b1;
                DECODE: begin
                    if (!(is_addu || is_subu || is_ori || is_lui || is_lw || is_sw ||
                          is_beq || is_j || is_jal || is_jr)) begin
                        illegal = 1'b1;
                        pc_we   = 1'b1;
                    end
                end
                EXEC_R: alu_op = is_subu ? ALU_SUB : ALU_ADD;
                EXEC_I: begin
                    alu_bsel = 1'b1;
                    alu_op   = is_lui ? ALU_LUI : ALU_OR;
                end
                WB_ALU: begin
                    rf_we   = 1'b1;
                    rf_wsel = is_rtype ? 2'd1 : 2'd0;
                    pc_we   = 1'b1;
                end
                MEM_ADDR, MEM_RD, MEM_WR: begin
                    alu_bsel = 1'b1;
                    ext_op   = 1'b1;
                    dm_re    = (state_q == MEM_RD);
                    dm_we    = (state_q == MEM_WR);
                    pc_we    = (state_q == MEM_WR) && dm_ok;
                end
                WB_MEM: begin
                    rf_we   = 1'b1;
                    rf_dsel = 2'd1;
                    pc_we   = 1'b1;
                end
                BRANCH: begin
                    alu_op  = ALU_SUB;
                    pc_we   = 1'b1;
                    npc_sel = zero ? IFU_SEL_RELATIVE : IFU_SEL_NORM;
                end
                JUMP: begin
                    pc_we = 1'b1;
                    if (is_jr) begin
                        npc_sel = IFU_SEL_REGISTER;
                    end else begin
                        npc_sel = IFU_SEL_IRRELATIVE;
                        if (is_jal) begin
                            rf_we   = 1'b1;
                            rf_wsel = 2'd2;
                            rf_dsel = 2'd2;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl against a per-instruction cycle model.
// Exercises the MC_CTRL_WAIT_EN handshake when that macro is defined for the build.
module tb_mc_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
`ifdef MC_CTRL_WAIT_EN
    logic       im_rdy;
    logic       dm_rdy;
`endif
    logic       ir_we, pc_we, rf_we, alu_bsel, ext_op, dm_re, dm_we, illegal;
    logic [1:0] npc_sel, rf_wsel, rf_dsel;
    logic [2:0] alu_op;
    logic [3:0] state;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
`ifdef MC_CTRL_WAIT_EN
        .im_rdy(im_rdy), .dm_rdy(dm_rdy),
`endif
        .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .rf_we(rf_we),
        .rf_wsel(rf_wsel), .rf_dsel(rf_dsel), .alu_op(alu_op), .alu_bsel(alu_bsel),
        .ext_op(ext_op), .dm_re(dm_re), .dm_we(dm_we), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [20:0] obs;
    assign obs = {state, ir_we, pc_we, npc_sel, rf_we, rf_wsel, rf_dsel,
                  alu_op, alu_bsel, ext_op, dm_re, dm_we, illegal};

    typedef struct {
        logic [20:0] v;
        logic        im;
        logic        dm;
    } step_t;

    step_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Expected output vector in the same field order as obs.
    function automatic logic [20:0] mk(input int st, input int ir, input int pc, input int npc,
                                       input int rfwe, input int wsel, input int dsel,
                                       input int aop, input int bsel, input int ext,
                                       input int re, input int we, input int ill);
        return {st[3:0], ir[0], pc[0], npc[1:0], rfwe[0], wsel[1:0], dsel[1:0],
                aop[2:0], bsel[0], ext[0], re[0], we[0], ill[0]};
    endfunction

    function automatic void push(input logic [20:0] v, input logic im, input logic dm);
        step_t s;
        s.v = v; s.im = im; s.dm = dm;
        exp_q.push_back(s);
    endfunction

    // Instruction mnemonic derived from the ISA table.
    function automatic string mnem(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00:   return (f == 6'h21) ? "addu" : (f == 6'h23) ? "subu" :
                            (f == 6'h08) ? "jr" : "bad";
            6'h0D:   return "ori";
            6'h0F:   return "lui";
            6'h23:   return "lw";
            6'h2B:   return "sw";
            6'h04:   return "beq";
            6'h02:   return "j";
            6'h03:   return "jal";
            default: return "bad";
        endcase
    endfunction

    // Cycle-by-cycle expectation for one whole instruction (states: F0 D1 ER2 EI3 WA4 MA5 MR6 WM7 MW8 BR9 JP10).
    function automatic void applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z,
                                          input int wi, input int wd);
        string m = mnem(o, f);
        exp_q.delete();
        for (int i = 0; i <= wi; i++) push(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), i == wi, 1'b1);
        if (m == "bad") begin
            push(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 1'b1);
            return;
        end
        push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
        case (m)
            "addu", "subu": begin
                push(mk(2, 0, 0, 0, 0, 0, 0, (m == "subu") ? 1 : 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
                push(mk(4, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
            end
            "ori", "lui": begin
                push(mk(3, 0, 0, 0, 0, 0, 0, (m == "lui") ? 3 : 2, 1, 0, 0, 0, 0), 1'b1, 1'b1);
                push(mk(4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
            end
            "lw": begin
                push(mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1'b1, 1'b1);
                for (int k = 0; k <= wd; k++)
                    push(mk(6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), 1'b1, k == wd);
                push(mk(7, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
            end
            "sw": begin
                push(mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1'b1, 1'b1);
                for (int k = 0; k <= wd; k++)
                    push(mk(8, 0, (k == wd) ? 1 : 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0), 1'b1, k == wd);
            end
            "beq":  push(mk(9, 0, 1, z ? 1 : 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, 1'b1);
            "j":    push(mk(10, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
            "jal":  push(mk(10, 0, 1, 2, 1, 2, 2, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
            default: push(mk(10, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
        endcase
    endfunction

    int instr_no = 0;

    // Runs one instruction from FETCH; abort_state >= 0 asserts reset once that state is seen.
    task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int wi_in, input int wd_in, input int abort_state);
        int wi = wi_in;
        int wd = wd_in;
        int pc_cnt = 0;
`ifndef MC_CTRL_WAIT_EN
        wi = 0;
        wd = 0;
`endif
        applyStimulus(o, f, z, wi, wd);
        instr_no++;
        for (int c = 0; c < exp_q.size(); c++) begin
            op = o; funct = f; zero = z;
`ifdef MC_CTRL_WAIT_EN
            im_rdy = exp_q[c].im;
            dm_rdy = exp_q[c].dm;
`endif
            #1;
            checkOutput($sformatf("i%0d_%s_c%0d", instr_no, mnem(o, f), c), 32'(obs), 32'(exp_q[c].v));
            pc_cnt += int'(pc_we);
            if (abort_state >= 0 && int'(exp_q[c].v[20:17]) == abort_state) begin
                #1 reset = 1'b1;
                #1 checkOutput($sformatf("i%0d_abort_now", instr_no), 32'(obs), 32'd0);
                @(posedge clk);
                @(negedge clk);
                checkOutput($sformatf("i%0d_abort_next", instr_no), 32'(obs), 32'd0);
                reset = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput($sformatf("i%0d_pc_we_count", instr_no), 32'(pc_cnt), 32'd1);
    endtask

    logic [5:0] tbl_op [10] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h00};
    logic [5:0] tbl_fn [10] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};

    initial begin
        reset = 1'b1;
        op = 6'h00; funct = 6'h00; zero = 1'b0;
`ifdef MC_CTRL_WAIT_EN
        im_rdy = 1'b1;
        dm_rdy = 1'b1;
`endif
        @(negedge clk);
        #1 checkOutput("reset_a", 32'(obs), 32'd0);
        @(negedge clk);
        #1 checkOutput("reset_b", 32'(obs), 32'd0);
        reset = 1'b0;

        runInstr(6'h00, 6'h21, 1'b0, 3, 0, -1);
        runInstr(6'h23, 6'h00, 1'b0, 0, 1, -1);
        runInstr(6'h2B, 6'h00, 1'b0, 0, 2, -1);
        runInstr(6'h04, 6'h00, 1'b1, 0, 0, -1);
        runInstr(6'h04, 6'h00, 1'b0, 0, 0, -1);
        runInstr(6'h03, 6'h00, 1'b0, 0, 0, -1);
        runInstr(6'h00, 6'h08, 1'b0, 0, 0, -1);
        runInstr(6'h3F, 6'h00, 1'b0, 0, 0, -1);
        runInstr(6'h23, 6'h00, 1'b0, 0, 0, 6);
        runInstr(6'h0D, 6'h00, 1'b0, 0, 0, -1);

        for (int n = 0; n < 250; n++) begin
            logic [5:0] o, f;
            int sel = $urandom_range(0, 12);
            if (sel < 10) begin
                o = tbl_op[sel];
                f = (o == 6'h00) ? tbl_fn[sel] : 6'($urandom);
            end else begin
                o = 6'($urandom);
                f = 6'($urandom);
            end
            runInstr(o, f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                     ($urandom_range(0, 19) == 0) ? $urandom_range(1, 10) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
